// File: rtl/hazard_if.sv
// hazard_if: bundles the pipeline-side signals of the hazard controller.
//   master modport : pipeline side. It drives the stage status and reads the controls.
//   slave modport  : hazard_ctrl side.
//   Stage status   : idu_* (ID operands), exu_* (EX destination, load, redirect),
//                    mmu_req / mmu_ready (MEM access handshake)
//   Controls       : ifu/idu/exu/mmu_stall, exu_bubble, idu_flush, mem_timeout
//   HAZARD_PERF_CNT_EN : adds perf_stall_cnt / perf_flush_cnt
interface hazard_if;
    logic       idu_valid;
    logic [4:0] idu_index_rs1;
    logic [4:0] idu_index_rs2;
    logic       idu_use_rs1;
    logic       idu_use_rs2;
    logic       exu_valid;
    logic [4:0] exu_index_rd;
    logic       exu_wb_en;
    logic       exu_is_load;
    logic       exu_redirect;
    logic       mmu_req;
    logic       mmu_ready;

    logic       ifu_stall;
    logic       idu_stall;
    logic       exu_stall;
    logic       mmu_stall;
    logic       exu_bubble;
    logic       idu_flush;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output idu_valid, idu_index_rs1, idu_index_rs2, idu_use_rs1, idu_use_rs2,
               exu_valid, exu_index_rd, exu_wb_en, exu_is_load, exu_redirect,
               mmu_req, mmu_ready,
`ifdef HAZARD_PERF_CNT_EN
        input  perf_stall_cnt, perf_flush_cnt,
`endif
        input  ifu_stall, idu_stall, exu_stall, mmu_stall, exu_bubble, idu_flush,
               mem_timeout
    );

    modport slave (
        input  idu_valid, idu_index_rs1, idu_index_rs2, idu_use_rs1, idu_use_rs2,
               exu_valid, exu_index_rd, exu_wb_en, exu_is_load, exu_redirect,
               mmu_req, mmu_ready,
`ifdef HAZARD_PERF_CNT_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output ifu_stall, idu_stall, exu_stall, mmu_stall, exu_bubble, idu_flush,
               mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//   It handles load-use stalls, memory-wait holds and the redirect flush sequence.
//   Ports: clk, rst_n (asynchronous, active low), hif (hazard_if.slave).
//   The stall, bubble and flush controls are combinational from the state and
//   the inputs. mem_timeout is a registered, sticky flag.
//   Optional: `define HAZARD_PERF_CNT_EN adds the stall and flush cycle counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // 1..7
    parameter int TIMEOUT      = 255  // 1..255
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hif
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_V    = 8'(TIMEOUT);

    state_t     state;
    logic       resume_flush;   // state to resume after MEM_WAIT: 1 = FLUSH, 0 = RUN
    logic [2:0] flush_cnt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       mem_timeout_q;

    logic mem_busy, load_use, in_flush, rs1_hit, rs2_hit;

    assign mem_busy = hif.mmu_req & ~hif.mmu_ready;
    assign rs1_hit  = hif.idu_use_rs1 & (hif.idu_index_rs1 == hif.exu_index_rd);
    assign rs2_hit  = hif.idu_use_rs2 & (hif.idu_index_rs2 == hif.exu_index_rd);
    assign load_use = hif.exu_valid & hif.exu_is_load & hif.exu_wb_en &
                      (hif.exu_index_rd != 5'd0) & hif.idu_valid & (rs1_hit | rs2_hit);

    // In the first non-busy MEM_WAIT cycle, the outputs are decoded as if the
    // block were already back in the resumed state.
    assign in_flush = (state == FLUSH) | ((state == MEM_WAIT) & resume_flush);

    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // Control decode with priority mem_busy > redirect > flush in progress > load_use.
    always_comb begin
        hif.ifu_stall  = 1'b0;
        hif.idu_stall  = 1'b0;
        hif.exu_stall  = 1'b0;
        hif.mmu_stall  = 1'b0;
        hif.exu_bubble = 1'b0;
        hif.idu_flush  = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                hif.ifu_stall = 1'b1;
                hif.idu_stall = 1'b1;
                hif.exu_stall = 1'b1;
                hif.mmu_stall = 1'b1;
            end else if (hif.exu_redirect | in_flush) begin
                hif.idu_flush  = 1'b1;
                hif.exu_bubble = 1'b1;
            end else if (load_use) begin
                hif.ifu_stall  = 1'b1;
                hif.idu_stall  = 1'b1;
                hif.exu_bubble = 1'b1;
            end
        end
    end

    assign hif.mem_timeout = mem_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            resume_flush  <= 1'b0;
            flush_cnt     <= 3'd0;
            wait_cnt      <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else if (mem_busy) begin
            // flush_cnt is frozen during the wait. Remember where to resume.
            state <= MEM_WAIT;
            if (state != MEM_WAIT)
                resume_flush <= (state == FLUSH);
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT_V)
                mem_timeout_q <= 1'b1;
        end else begin
            wait_cnt <= 8'd0;
            if (hif.exu_redirect) begin
                // The redirect cycle is the first flush cycle.
                // FLUSH covers the remaining FLUSH_CYCLES-1 cycles.
                if (FLUSH_CYCLES > 1) begin
                    state     <= FLUSH;
                    flush_cnt <= FLUSH_RELOAD;
                end else begin
                    state     <= RUN;
                    flush_cnt <= 3'd0;
                end
            end else if (in_flush) begin
                if (flush_cnt <= 3'd1) begin
                    state     <= RUN;
                    flush_cnt <= 3'd0;
                end else begin
                    state     <= FLUSH;
                    flush_cnt <= flush_cnt - 3'd1;
                end
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (hif.ifu_stall) perf_stall_q <= perf_stall_q + 32'd1;
            if (hif.idu_flush) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign hif.perf_stall_cnt = perf_stall_q;
    assign hif.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int FC = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_if hif();
    hazard_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model.
    // flush_left is the number of flush cycles still owed after this one.
    // busy_run is the number of consecutive busy cycles.
    int          flush_left = 0;
    int          busy_run   = 0;
    bit          m_timeout  = 1'b0;
    logic [31:0] m_pstall   = 0;
    logic [31:0] m_pflush   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input bit ev, input logic [4:0] rd,
                         input bit wb, input bit ld, input bit redir, input bit req,
                         input bit rdy);
        hif.idu_valid = iv; hif.idu_index_rs1 = rs1; hif.idu_index_rs2 = rs2;
        hif.idu_use_rs1 = u1; hif.idu_use_rs2 = u2;
        hif.exu_valid = ev; hif.exu_index_rd = rd; hif.exu_wb_en = wb;
        hif.exu_is_load = ld; hif.exu_redirect = redir;
        hif.mmu_req = req; hif.mmu_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic bit model_load_use();
        bit hit1 = hif.idu_use_rs1 && hif.idu_index_rs1 == hif.exu_index_rd;
        bit hit2 = hif.idu_use_rs2 && hif.idu_index_rs2 == hif.exu_index_rd;
        return hif.exu_valid && hif.exu_is_load && hif.exu_wb_en &&
               hif.exu_index_rd != 0 && hif.idu_valid && (hit1 || hit2);
    endfunction

    // Checks one cycle. The inputs must already be applied.
    // If use_lit is set, the controls {ifu,idu,exu,mmu stall, bubble, flush}
    // are also compared against the literal lit.
    task automatic step(input string tag, input bit use_lit, input logic [5:0] lit);
        bit busy, redir, lu;
        logic [5:0] e;
        logic [5:0] obs;
        @(negedge clk);
        busy  = hif.mmu_req && !hif.mmu_ready;
        redir = hif.exu_redirect;
        lu    = model_load_use();
        if (busy)                        e = 6'b111100;
        else if (redir || flush_left > 0) e = 6'b000011;
        else if (lu)                     e = 6'b110010;
        else                             e = 6'b000000;
        obs = {hif.ifu_stall, hif.idu_stall, hif.exu_stall, hif.mmu_stall,
               hif.exu_bubble, hif.idu_flush};
        chk({tag, ".ctrl"}, 32'(obs), 32'(e));
        chk({tag, ".timeout"}, 32'(hif.mem_timeout), 32'(m_timeout));
        if (use_lit) chk({tag, ".lit"}, 32'(obs), 32'(lit));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".pstall"}, hif.perf_stall_cnt, m_pstall);
        chk({tag, ".pflush"}, hif.perf_flush_cnt, m_pflush);
`endif
        @(posedge clk);
        if (e[5]) m_pstall = m_pstall + 1;
        if (e[0]) m_pflush = m_pflush + 1;
        if (busy) begin
            busy_run++;
            if (busy_run >= TO) m_timeout = 1'b1;
        end else begin
            busy_run = 0;
            if (redir)               flush_left = FC - 1;
            else if (flush_left > 0) flush_left--;
        end
        #1;
    endtask

    task automatic model_reset();
        flush_left = 0; busy_run = 0; m_timeout = 1'b0; m_pstall = 0; m_pflush = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({hif.ifu_stall, hif.idu_stall, hif.exu_stall, hif.mmu_stall,
                      hif.exu_bubble, hif.idu_flush, hif.mem_timeout}), 32'd0);
    endtask

    initial begin
        // The inputs would request every control while reset is held.
        drive(1, 5, 5, 1, 1, 1, 5, 1, 1, 1, 1, 0);
        #2 chk_all_zero("reset_outputs");
        #20 idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        step("idle", 1, 6'b000000);

        // Load-use on rs1: a single stall cycle, then the pipe advances.
        drive(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0); step("lu_rs1", 1, 6'b110010);
        idle();                                    step("lu_after", 1, 6'b000000);
        drive(1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0); step("lu_rd0", 1, 6'b000000);
        drive(1, 0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0); step("lu_rs2_unused", 1, 6'b000000);
        drive(1, 0, 5, 0, 1, 1, 5, 1, 1, 0, 0, 0); step("lu_rs2", 1, 6'b110010);
        drive(1, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0); step("alu_fwd", 1, 6'b000000);

        // Redirect: FC flush cycles.
        idle(); hif.exu_redirect = 1'b1;           step("redir0", 1, 6'b000011);
        idle();                                    step("redir1", 1, 6'b000011);
        drive(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0); step("redir_done", 1, 6'b110010);

        // Memory wait: 4 busy cycles, then ready.
        idle();
        for (int i = 0; i < 4; i++) begin
            hif.mmu_req = 1'b1; hif.mmu_ready = 1'b0; step("memwait", 1, 6'b111100);
        end
        hif.mmu_ready = 1'b1;                      step("memready", 1, 6'b000000);

        // Busy, redirect and load-use coincide. The redirect waits for the memory access.
        drive(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 1, 0); step("coin0", 1, 6'b111100);
                                                   step("coin1", 1, 6'b111100);
        hif.mmu_ready = 1'b1;                      step("coin_rel", 1, 6'b000011);
        idle();                                    step("coin_fl", 1, 6'b000011);
                                                   step("coin_done", 1, 6'b000000);

        // A memory wait in FLUSH freezes the remaining flush cycles.
        hif.exu_redirect = 1'b1;                   step("fz_redir", 1, 6'b000011);
        idle(); hif.mmu_req = 1'b1;
        for (int i = 0; i < 3; i++)                step("fz_busy", 1, 6'b111100);
        hif.mmu_req = 1'b0;                        step("fz_resume", 1, 6'b000011);
                                                   step("fz_done", 1, 6'b000000);

        // Timeout: 10 busy cycles with TO=8.
        hif.mmu_req = 1'b1;
        for (int i = 0; i < 10; i++)               step("tmo", 1, 6'b111100);
        chk("tmo_sticky", 32'(hif.mem_timeout), 32'd1);

        // Reset asserted in the middle of the wait.
        @(negedge clk) rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge clk) #1 chk_all_zero("midreset_edge");
        idle();
        #2 rst_n = 1'b1;
        model_reset();
        step("post_reset", 1, 6'b000000);
        hif.exu_redirect = 1'b1;                   step("post_reset_run", 1, 6'b000011);
        idle();                                    step("post_reset_fl", 1, 6'b000011);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] regs [3];
            regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5;
            drive($urandom_range(0, 3) != 0, regs[$urandom_range(0, 2)],
                  regs[$urandom_range(0, 2)], 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, regs[$urandom_range(0, 2)],
                  1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom));
            step("rand", 0, 6'b000000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
